// File: rtl/bloco_controle_if.sv
// bloco_controle handshake/control bundle.
// Start request in, datapath control word and status out.
interface bloco_controle_if;
    logic       iniciar;
    logic [1:0] op;
    logic       LX;
    logic       LH;
    logic       LS;
    logic [1:0] M0;
    logic [1:0] M1;
    logic [1:0] M2;
    logic       H;
    logic       ocupado;
    logic       pronto;

    modport master (
        output iniciar, op,
        input  LX, LH, LS, M0, M1, M2, H, ocupado, pronto
    );

    modport slave (
        input  iniciar, op,
        output LX, LH, LS, M0, M1, M2, H, ocupado, pronto
    );
endinterface

// File: rtl/bloco_controle.sv
// bloco_controle: sequencer for the 16-bit datapath.
// Moore FSM with registered control word and status outputs.
module bloco_controle (
    input logic        clk,
    input logic        rst_n,
    bloco_controle_if.slave bus
);
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EXECUTA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    typedef struct packed {
        logic       lx;
        logic       lh;
        logic       ls;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
    } ctrl_t;

    estado_t    estado;
    estado_t    proxEstado;
    logic [2:0] passo;
    logic [2:0] proxPasso;
    logic [1:0] opR;
    logic [1:0] proxOp;
    ctrl_t      ctrl;
    logic       ocupadoR;
    logic       prontoR;

    function automatic ctrl_t palavra(
        input logic [1:0] m0,
        input logic [1:0] m2,
        input logic [1:0] m1,
        input logic       h,
        input logic       lx,
        input logic       lh,
        input logic       ls
    );
        ctrl_t c;
        c.lx = lx;
        c.lh = lh;
        c.ls = ls;
        c.m0 = m0;
        c.m1 = m1;
        c.m2 = m2;
        c.h  = h;
        return c;
    endfunction

    function automatic logic [2:0] ultimo(input logic [1:0] o);
        logic [2:0] u;
        case (o)
            2'b10:   u = 3'd3;
            2'b11:   u = 3'd2;
            default: u = 3'd4;
        endcase
        return u;
    endfunction

    // Step 0 is the shared INIT (X=K, S=0, Hreg=0); the rest is per program.
    function automatic ctrl_t decodifica(
        input logic [1:0] o,
        input logic [2:0] p
    );
        ctrl_t c;
        c = '0;
        if (p == 3'd0) begin
            c = palavra(2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        end else begin
            case (o)
                2'b00: begin
                    case (p)
                        3'd1: c = palavra(2'b01, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
                        3'd2: c = palavra(2'b10, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
                        3'd3: c = palavra(2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
                        3'd4: c = palavra(2'b11, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
                        default: c = '0;
                    endcase
                end
                2'b01: begin
                    case (p)
                        3'd1: c = palavra(2'b01, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
                        3'd2: c = palavra(2'b10, 2'b01, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
                        3'd3: c = palavra(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
                        3'd4: c = palavra(2'b00, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
                        default: c = '0;
                    endcase
                end
                2'b10: begin
                    case (p)
                        3'd1: c = palavra(2'b01, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
                        3'd2: c = palavra(2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
                        3'd3: c = palavra(2'b11, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
                        default: c = '0;
                    endcase
                end
                default: begin
                    case (p)
                        3'd1: c = palavra(2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
                        3'd2: c = palavra(2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
                        default: c = '0;
                    endcase
                end
            endcase
        end
        return c;
    endfunction

    // Next state: start only from idle, run to the program's last step, then one FIM cycle.
    always_comb begin
        proxEstado = estado;
        proxPasso  = passo;
        proxOp     = opR;
        case (estado)
            OCIOSO: begin
                if (bus.iniciar) begin
                    proxEstado = EXECUTA;
                    proxPasso  = 3'd0;
                    proxOp     = bus.op;
                end
            end
            EXECUTA: begin
                if (passo == ultimo(opR)) begin
                    proxEstado = FIM;
                end else begin
                    proxPasso = passo + 3'd1;
                end
            end
            FIM: begin
                proxEstado = OCIOSO;
            end
            default: begin
                proxEstado = OCIOSO;
            end
        endcase
    end

    // State plus registered Moore outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= OCIOSO;
            passo    <= 3'd0;
            opR      <= 2'b00;
            ctrl     <= '0;
            ocupadoR <= 1'b0;
            prontoR  <= 1'b0;
        end else begin
            estado   <= proxEstado;
            passo    <= proxPasso;
            opR      <= proxOp;
            ctrl     <= (proxEstado == EXECUTA) ? decodifica(proxOp, proxPasso) : '0;
            ocupadoR <= (proxEstado == EXECUTA);
            prontoR  <= (proxEstado == FIM);
        end
    end

    assign bus.LX      = ctrl.lx;
    assign bus.LH      = ctrl.lh;
    assign bus.LS      = ctrl.ls;
    assign bus.M0      = ctrl.m0;
    assign bus.M1      = ctrl.m1;
    assign bus.M2      = ctrl.m2;
    assign bus.H       = ctrl.h;
    assign bus.ocupado = ocupadoR;
    assign bus.pronto  = prontoR;
endmodule

// File: tb/tb_bloco_controle.sv
// Bench for bloco_controle: expected-cycle queue model plus a
// behavioural 16-bit datapath that turns control words into S.
module tb_bloco_controle;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bloco_controle_if bus();

    bloco_controle dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [15:0] A, B, C, K;
    logic [15:0] mX, mH, mS;

    logic [11:0] q[$];
    int busyCnt = 0;
    int pulseCnt = 0;
    int cycNo = 0;
    int prontoAt[$];
    int sAt[$];

    wire [11:0] outs = {bus.LX, bus.LH, bus.LS, bus.M0, bus.M1, bus.M2,
                        bus.H, bus.ocupado, bus.pronto};

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int nSteps(input logic [1:0] o);
        if (o == 2'd2) return 4;
        if (o == 2'd3) return 3;
        return 5;
    endfunction

    function automatic logic [9:0] mk(
        input logic [1:0] m0, input logic [1:0] m2, input logic [1:0] m1,
        input logic h, input logic lx, input logic lh, input logic ls);
        return {lx, lh, ls, m0, m1, m2, h};
    endfunction

    // Control word of step k of program o, straight from the program listings.
    function automatic logic [9:0] stepWord(input logic [1:0] o, input int k);
        logic [1:0] kk;
        kk = k[1:0];
        if (k == 0) return mk(2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        case (o)
            2'd0: case (k)
                1: return mk(2'd1, 2'd1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
                2: return mk(2'd2, 2'd1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
                3: return mk(2'd0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
                default: return mk(2'd3, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
            endcase
            2'd1: case (k)
                1: return mk(2'd1, 2'd1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
                2: return mk(2'd2, 2'd1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
                3: return mk(2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
                default: return mk(2'd0, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
            endcase
            2'd2: return mk(kk, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
            default: case (k)
                1: return mk(2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
                default: return mk(2'd1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
            endcase
        endcase
    endfunction

    // Model: queue of expected per-cycle outputs; empty queue means idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (q.size() != 0) begin
                void'(q.pop_front());
            end else if (bus.iniciar) begin
                for (int k = 0; k < nSteps(bus.op); k++)
                    q.push_back({stepWord(bus.op, k), 2'b10});
                q.push_back(12'h001);
            end
        end
    end

    // Behavioural datapath driven by the DUT's control word.
    always @(posedge clk) begin
        logic [15:0] mux0, a, b, r;
        case (bus.M0)
            2'd0: mux0 = 16'd0;
            2'd1: mux0 = A;
            2'd2: mux0 = B;
            default: mux0 = C;
        endcase
        case (bus.M1)
            2'd0: b = mux0;
            2'd1: b = mX;
            2'd2: b = mS;
            default: b = mH;
        endcase
        case (bus.M2)
            2'd0: a = mX;
            2'd1: a = mux0;
            2'd2: a = mS;
            default: a = mH;
        endcase
        r = bus.H ? a * b : a + b;
        if (bus.LX) mX = K;
        if (bus.LH) mH = r;
        if (bus.LS) mS = r;
    end

    always @(posedge clk) cycNo++;

    // Compare every cycle against the model, and collect status events.
    always @(negedge clk) begin
        logic [11:0] e;
        e = (q.size() != 0) ? q[0] : 12'h000;
        chk("ctrl", int'(outs), int'(e));
        if (bus.ocupado) busyCnt++;
        if (bus.pronto) begin
            pulseCnt++;
            prontoAt.push_back(cycNo);
            sAt.push_back(int'(mS));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic waitPronto(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.pronto) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run(input logic [1:0] o,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] k,
                       input int expS, input int expLat, input string nm);
        int lat;
        A = a; B = b; C = c; K = k;
        bus.op = o;
        bus.iniciar = 1'b1;
        busyCnt = 0;
        cyc(1);
        bus.iniciar = 1'b0;
        @(negedge clk);
        #1;
        chk({nm, "_init"}, int'(outs), 12'hE0A);
        waitPronto(lat);
        if (lat > 0) lat = lat + 1;
        chk({nm, "_lat"}, lat, expLat);
        chk({nm, "_S"}, int'(mS), expS);
        chk({nm, "_busy"}, busyCnt, expLat - 1);
        cyc(2);
    endtask

    initial begin
        int lat;
        bus.iniciar = 1'b0;
        bus.op = 2'b00;
        A = 0; B = 0; C = 0; K = 0;
        #12;
        chk("rst_outs", int'(outs), 0);
        cyc(1);
        rst_n = 1'b1;
        busyCnt = 0;
        pulseCnt = 0;
        cyc(10);
        chk("idle_busy", busyCnt, 0);
        chk("idle_pronto", pulseCnt, 0);

        run(2'd0, 16'd3, 16'd4, 16'd6, 16'd2, 20, 6, "op00");
        run(2'd1, 16'd3, 16'd4, 16'd6, 16'd2, 24, 6, "op01");
        run(2'd2, 16'd3, 16'd4, 16'd6, 16'd2, 13, 5, "op10");
        run(2'd3, 16'd3, 16'd4, 16'd6, 16'd2, 12, 4, "op11");
        run(2'd3, 16'd300, 16'd0, 16'd0, 16'd300, 64704, 4, "wrap");

        A = 3; B = 4; C = 6; K = 2;
        bus.op = 2'd0;
        bus.iniciar = 1'b1;
        cyc(1);
        bus.iniciar = 1'b0;
        cyc(2);
        bus.op = 2'd3;
        bus.iniciar = 1'b1;
        cyc(1);
        bus.iniciar = 1'b0;
        waitPronto(lat);
        chk("midop_seen", int'(lat > 0), 1);
        chk("midop_S", int'(mS), 20);
        cyc(3);

        bus.op = 2'd0;
        bus.iniciar = 1'b1;
        cyc(1);
        bus.iniciar = 1'b0;
        cyc(2);
        chk("step2_busy", int'(bus.ocupado), 1);
        #1;
        pulseCnt = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid", int'(outs), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        chk("rst_nopronto", pulseCnt, 0);

        bus.op = 2'd2;
        A = 3; B = 4; C = 6; K = 2;
        prontoAt.delete();
        sAt.delete();
        bus.iniciar = 1'b1;
        cyc(20);
        bus.iniciar = 1'b0;
        cyc(8);
        chk("held_count", int'(prontoAt.size() >= 3), 1);
        for (int i = 1; i < prontoAt.size(); i++)
            chk("held_period", prontoAt[i] - prontoAt[i-1], 6);
        foreach (sAt[i])
            chk("held_S", sAt[i], 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
